// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port between the scanout block (master) and the BRAM (slave).
interface vga_fb_scanout_if #(
  parameter int ADDR_W = 17
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;

  modport master (output fb_rd_en, output fb_addr, input  fb_data);
  modport slave  (input  fb_rd_en, input  fb_addr, output fb_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// 640x480 VGA scanout: reads a 2x pixel-doubled 320x240 RGB444 framebuffer,
// optionally overlays the ROI outline, and aligns data, de and syncs at the pins.
module vga_fb_scanout #(
  parameter int          FB_W       = 320,
  parameter int          FB_H       = 240,
  parameter int          ADDR_W     = 17,
  parameter int          RD_LAT     = 2,   // 1..4
  parameter int          ROI_X0     = 264,
  parameter int          ROI_Y0     = 184,
  parameter int          ROI_SIZE   = 112,
  parameter int          BORDER_W   = 2,
  parameter logic [11:0] BORDER_RGB = 12'hF00
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 de_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 roi_en,
  vga_fb_scanout_if.master     fb,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic                 frame_start
);

  localparam int L    = RD_LAT + 2;
  localparam int DE_D = L - 1;  // taps ahead of the output register
  localparam int SY_D = L - 2;  // syncs already lag x by one cycle

  localparam logic [9:0] X_LAST = 10'(2*FB_W - 1);
  localparam logic [9:0] Y_END  = 10'(2*FB_H);
  localparam logic [9:0] RX_LO  = 10'(ROI_X0);
  localparam logic [9:0] RX_HI  = 10'(ROI_X0 + ROI_SIZE);
  localparam logic [9:0] RX_BL  = 10'(ROI_X0 + BORDER_W);
  localparam logic [9:0] RX_BH  = 10'(ROI_X0 + ROI_SIZE - BORDER_W);
  localparam logic [9:0] RY_LO  = 10'(ROI_Y0);
  localparam logic [9:0] RY_HI  = 10'(ROI_Y0 + ROI_SIZE);
  localparam logic [9:0] RY_BL  = 10'(ROI_Y0 + BORDER_W);
  localparam logic [9:0] RY_BH  = 10'(ROI_Y0 + ROI_SIZE - BORDER_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  logic              w_frame0, w_roi_act, w_in_roi, w_edge, w_border, w_fs;
  logic [ADDR_W-1:0] w_row_base, w_col;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_roi_en;
  logic [DE_D-1:0]   r_vld_pipe, r_bd_pipe, r_fs_pipe;
  logic [SY_D-1:0]   r_hs_pipe, r_vs_pipe;

  // Stage 0: frame boundary, ROI outline and address terms from the raw counters
  assign w_frame0   = (x == 10'd0) && (y == 10'd0);
  assign w_roi_act  = w_frame0 ? roi_en : r_roi_en;
  assign w_in_roi   = (x >= RX_LO) && (x < RX_HI) && (y >= RY_LO) && (y < RY_HI);
  assign w_edge     = (x < RX_BL) || (x >= RX_BH) || (y < RY_BL) || (y >= RY_BH);
  assign w_border   = w_roi_act && w_in_roi && w_edge;
  assign w_fs       = w_frame0 && de_in;
  assign w_row_base = w_frame0 ? '0 : r_row_base;
  assign w_col      = ADDR_W'(x[9:1]);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_roi_en <= 1'b0;
    end else if (w_frame0) begin
      r_roi_en <= roi_en;
    end
  end

  // Row base advances after the second screen line of each framebuffer row
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base <= '0;
    end else if (w_frame0) begin
      r_row_base <= '0;
    end else if ((x == X_LAST) && y[0] && (y < Y_END)) begin
      r_row_base <= r_row_base + ROW_STEP;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      fb.fb_rd_en <= 1'b0;
      fb.fb_addr  <= '0;
    end else begin
      fb.fb_rd_en <= de_in;
      fb.fb_addr  <= de_in ? (w_row_base + w_col) : '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_bd_pipe  <= '0;
      r_fs_pipe  <= '0;
      r_hs_pipe  <= '1;
      r_vs_pipe  <= '1;
    end else begin
      r_vld_pipe[0] <= de_in;
      r_bd_pipe[0]  <= w_border;
      r_fs_pipe[0]  <= w_fs;
      r_hs_pipe[0]  <= hsync_in;
      r_vs_pipe[0]  <= vsync_in;
      for (int i = 1; i < DE_D; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_bd_pipe[i]  <= r_bd_pipe[i-1];
        r_fs_pipe[i]  <= r_fs_pipe[i-1];
      end
      for (int i = 1; i < SY_D; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  // Output register: fb_data is only looked at when its read was enabled
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_de      <= r_vld_pipe[DE_D-1];
      vga_hs      <= r_hs_pipe[SY_D-1];
      vga_vs      <= r_vs_pipe[SY_D-1];
      frame_start <= r_fs_pipe[DE_D-1];
      if (!r_vld_pipe[DE_D-1])
        {vga_r, vga_g, vga_b} <= 12'h000;
      else if (r_bd_pipe[DE_D-1])
        {vga_r, vga_g, vga_b} <= BORDER_RGB;
      else
        {vga_r, vga_g, vga_b} <= fb.fb_data;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench: a compressed 800x525 timing model (most lines skip their middle)
// driving vga_fb_scanout, with a BRAM model that returns address[11:0].
module tb_vga_fb_scanout;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       de_in, hsync_in, vsync_in, roi_en;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de, frame_start;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, fs_cnt = 0, de_acc = 0, last_frame_de = 0;
  int blank_bad = 0, hs_bad = 0, addr_bad = 0;
  int hs_fall = 0, hs_w = 0, hs_off = 0, de_fall = 0, vs_fall = 0, vs_w = 0;
  logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;

  logic [11:0] r_d1, r_d2;

  always #5 pclk = ~pclk;

  vga_fb_scanout_if #(.ADDR_W(17)) fb_if ();

  vga_fb_scanout dut (
    .pclk(pclk), .rst_n(rst_n), .x(x), .y(y), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .roi_en(roi_en), .fb(fb_if),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
  );

  // Two-cycle BRAM; garbage when not enabled so blanking has something to hide
  always @(posedge pclk) begin
    r_d1 <= fb_if.fb_rd_en ? fb_if.fb_addr[11:0] : 12'hA5A;
    r_d2 <= r_d1;
  end
  assign fb_if.fb_data = r_d2;

  function automatic bit full_line(input int yy);
    return (yy == 184) || (yy == 200) || (yy == 250) || (yy == 295) || (yy == 490) || (yy == 491);
  endfunction

  task automatic tick();
    int nx, ny;
    @(posedge pclk); #1;
    cyc++;
    if (frame_start) begin fs_cnt++; last_frame_de = de_acc; de_acc = 0; end
    if (vga_de) de_acc++;
    if (!vga_de && {vga_r, vga_g, vga_b} != 12'h000) blank_bad++;
    if (vga_de && !p_de && !vga_hs) hs_bad++;
    if (fb_if.fb_addr > 17'd76799) addr_bad++;
    if (!vga_de && p_de) de_fall = cyc;
    if (!vga_hs && p_hs) begin hs_fall = cyc; hs_off = cyc - de_fall; end
    if (vga_hs && !p_hs) hs_w = cyc - hs_fall;
    if (!vga_vs && p_vs) vs_fall = cyc;
    if (vga_vs && !p_vs) vs_w = cyc - vs_fall;
    p_de = vga_de; p_hs = vga_hs; p_vs = vga_vs;
    // generator: syncs are the registered decode of the previous position
    hsync_in = !(x >= 656 && x < 752);
    vsync_in = !(y >= 490 && y < 492);
    nx = int'(x); ny = int'(y);
    if (nx == 799) begin nx = 0; ny = (ny == 524) ? 0 : ny + 1; end
    else if (!full_line(ny) && nx == 3) nx = 636;
    else if (!full_line(ny) && nx == 643) nx = 796;
    else nx = nx + 1;
    x = 10'(nx); y = 10'(ny);
    de_in = (nx < 640) && (ny < 480);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int px, input int py);
    int n = 0;
    while (!(int'(x) == px && int'(y) == py)) begin
      tick(); n++;
      if (n > 30000) begin
        n_cmp++; n_err++;
        $display("FAIL run_to(%0d,%0d) timeout at x=%0d y=%0d", px, py, x, y);
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; roi_en = 1'b0;
    x = 10'd780; y = 10'd524; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL reset_rgb got=%h exp=000", {vga_r, vga_g, vga_b}); end
    n_cmp++; if (vga_de !== 1'b0) begin n_err++; $display("FAIL reset_de got=%b exp=0", vga_de); end
    n_cmp++; if (vga_hs !== 1'b1) begin n_err++; $display("FAIL reset_hs got=%b exp=1", vga_hs); end
    n_cmp++; if (vga_vs !== 1'b1) begin n_err++; $display("FAIL reset_vs got=%b exp=1", vga_vs); end
    n_cmp++; if (fb_if.fb_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b exp=0", fb_if.fb_rd_en); end
    n_cmp++; if (fb_if.fb_addr !== 17'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", fb_if.fb_addr); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_pixels();
    run_to(0, 0); run(3);
    n_cmp++; if (vga_de !== 1'b0) begin n_err++; $display("FAIL lat_de_early got=%b exp=0", vga_de); end
    tick();
    n_cmp++; if (vga_de !== 1'b1) begin n_err++; $display("FAIL lat_de got=%b exp=1", vga_de); end
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_first got=%b exp=1", frame_start); end
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL pix_0_0 got=%h exp=000", {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL fs_width got=%b exp=0", frame_start); end
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL pix_1_0 got=%h exp=000", {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h001) begin n_err++; $display("FAIL pix_2_0 got=%h exp=001", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_addressing();
    run_to(0, 1); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL pix_0_1 got=%h exp=000", {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL pix_1_1 got=%h exp=000", {vga_r, vga_g, vga_b}); end
    run_to(264, 184); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h384) begin n_err++; $display("FAIL pix_264_184_off got=%h exp=384", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_roi_midframe();
    run_to(0, 200); roi_en = 1'b1;
    run_to(264, 250); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hCC4) begin n_err++; $display("FAIL roi_partial got=%h exp=CC4", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_sync_h();
    run_to(0, 296); run(4);
    n_cmp++; if (hs_w !== 96) begin n_err++; $display("FAIL hs_width got=%0d exp=96", hs_w); end
    n_cmp++; if (hs_off !== 16) begin n_err++; $display("FAIL hs_offset got=%0d exp=16", hs_off); end
  endtask

  task automatic test_addr_end();
    run_to(639, 479); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hBFF) begin n_err++; $display("FAIL pix_639_479 got=%h exp=BFF", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_sync_v();
    run_to(0, 490); run(3);
    n_cmp++; if (vga_vs !== 1'b1) begin n_err++; $display("FAIL vs_early got=%b exp=1", vga_vs); end
    tick();
    n_cmp++; if (vga_vs !== 1'b0) begin n_err++; $display("FAIL vs_fall got=%b exp=0", vga_vs); end
    run_to(0, 493); run(4);
    n_cmp++; if (vs_w !== 1600) begin n_err++; $display("FAIL vs_width got=%0d exp=1600", vs_w); end
  endtask

  task automatic test_frame_de();
    run_to(0, 0); run(4);
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_frame2 got=%b exp=1", frame_start); end
    // 4 full lines x640 + 476 compressed lines x8 active pixels
    n_cmp++; if (last_frame_de !== 6368) begin n_err++; $display("FAIL frame_de_count got=%0d exp=6368", last_frame_de); end
  endtask

  task automatic test_roi_frame();
    run_to(264, 184); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hF00) begin n_err++; $display("FAIL roi_264_184 got=%h exp=F00", {vga_r, vga_g, vga_b}); end
    run_to(265, 200); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hF00) begin n_err++; $display("FAIL roi_265_200 got=%h exp=F00", {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hD85) begin n_err++; $display("FAIL roi_266_200 got=%h exp=D85", {vga_r, vga_g, vga_b}); end
    run_to(264, 250); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hF00) begin n_err++; $display("FAIL roi_264_250 got=%h exp=F00", {vga_r, vga_g, vga_b}); end
    run_to(375, 295); run(4);
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'hF00) begin n_err++; $display("FAIL roi_375_295 got=%h exp=F00", {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h87C) begin n_err++; $display("FAIL roi_376_295 got=%h exp=87C", {vga_r, vga_g, vga_b}); end
    roi_en = 1'b0;
  endtask

  task automatic test_blanking();
    n_cmp++; if (blank_bad !== 0) begin n_err++; $display("FAIL blank_rgb got=%0d exp=0", blank_bad); end
    n_cmp++; if (hs_bad !== 0) begin n_err++; $display("FAIL de_rise_hs_low got=%0d exp=0", hs_bad); end
    n_cmp++; if (addr_bad !== 0) begin n_err++; $display("FAIL addr_range got=%0d exp=0", addr_bad); end
  endtask

  task automatic test_reset_midframe();
    run_to(300, 200);
    n_cmp++; if (vga_de !== 1'b1) begin n_err++; $display("FAIL pre_reset_de got=%b exp=1", vga_de); end
    rst_n = 1'b0; #1;
    n_cmp++; if (vga_de !== 1'b0) begin n_err++; $display("FAIL mid_reset_de got=%b exp=0", vga_de); end
    n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL mid_reset_rgb got=%h exp=000", {vga_r, vga_g, vga_b}); end
    n_cmp++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin n_err++; $display("FAIL mid_reset_sync got=%b%b exp=11", vga_hs, vga_vs); end
    n_cmp++; if (fb_if.fb_rd_en !== 1'b0 || fb_if.fb_addr !== 17'd0) begin n_err++; $display("FAIL mid_reset_fb got=%b/%0d exp=0/0", fb_if.fb_rd_en, fb_if.fb_addr); end
    run(3);
    rst_n = 1'b1;
    fs_cnt = 0;
    run(3);
    n_cmp++; if (vga_de !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL refill_blank got=%b/%h exp=0/000", vga_de, {vga_r, vga_g, vga_b}); end
    tick();
    n_cmp++; if (vga_de !== 1'b1) begin n_err++; $display("FAIL refill_de got=%b exp=1", vga_de); end
    run_to(0, 0); run(3);
    n_cmp++; if (fs_cnt !== 0) begin n_err++; $display("FAIL fs_before_frame got=%0d exp=0", fs_cnt); end
    tick();
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_after_reset got=%b exp=1", frame_start); end
    run(2);
    n_cmp++; if (fs_cnt !== 1) begin n_err++; $display("FAIL fs_count got=%0d exp=1", fs_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_addressing();
    test_roi_midframe();
    test_sync_h();
    test_addr_end();
    test_sync_v();
    test_frame_de();
    test_roi_frame();
    test_blanking();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Sits directly downstream of the 640x480 timing generator.
- Consumes the generator's registered x/y counters, de, hsync and vsync, and reads the camera framebuffer (320x240 RGB444 BRAM, 2x pixel-doubled).
- Optionally overlays the MNIST capture ROI outline on the video.
- Drives the VGA pins with data, de and syncs aligned on the same cycle.

Parameters:
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- ADDR_W, 17, framebuffer address width
- RD_LAT, 2, BRAM read latency in cycles (fb_rd_en/fb_addr to fb_data valid); legal 1..4
- ROI_X0, 264, ROI left edge in screen pixels
- ROI_Y0, 184, ROI top edge in screen pixels
- ROI_SIZE, 112, ROI side length in screen pixels (28x4)
- BORDER_W, 2, ROI outline thickness in pixels
- BORDER_RGB, 12'hF00, outline colour {R,G,B} 4 bits each

Ports:
- pclk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- x  in  10  horizontal counter from timing generator
- y  in  10  vertical counter from timing generator
- de_in  in  1  active-area flag from timing generator
- hsync_in  in  1  active-low hsync from timing generator (already registered there, one cycle after x)
- vsync_in  in  1  active-low vsync from timing generator
- roi_en  in  1  request ROI outline overlay
- fb_rd_en  out  1  framebuffer read enable
- fb_addr  out  ADDR_W  framebuffer read address
- fb_data  in  12  framebuffer read data {R[3:0],G[3:0],B[3:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  active-low hsync, aligned to pixel data
- vga_vs  out  1  active-low vsync, aligned to pixel data
- vga_de  out  1  active-area flag, aligned to pixel data
- frame_start  out  1  one-cycle pulse coincident with first active output pixel of each frame

Behaviour:
- Reset (async assert, sync release):
  - vga_r/g/b=0, vga_de=0, vga_hs=1, vga_vs=1
  - fb_rd_en=0, fb_addr=0, frame_start=0
  - delay-line taps: de=0, hs=1, vs=1, roi=0
  - latched roi_en=0
- Stage 1 (registered):
  - fb_rd_en <= de_in
  - fb_addr <= (y>>1)*FB_W + (x>>1) when de_in, else 0
  - Address built incrementally, no multiplier:
    - row_base resets to 0 when y==0 && x==0
    - row_base += FB_W at x==639 on odd y
    - column offset = x>>1
  - Max address 76799; never exceeds FB_W*FB_H-1.
- Total latency L = RD_LAT+2 (4 at default), from x/y/de_in to vga_* outputs.
  - de_in and the border flag are delayed L cycles in shift registers.
  - hsync_in/vsync_in are delayed L-1 cycles, because they already lag x by one.
  - Result: vga_hs/vga_vs keep exactly the generator's sync position relative to active video.
- Output register:
  - delayed de=0 -> RGB=0
  - delayed de=1 && delayed border=1 -> RGB=BORDER_RGB
  - otherwise RGB=fb_data
- Border flag (computed from x,y at stage 0):
  - Pixel lies inside [ROI_X0, ROI_X0+ROI_SIZE) x [ROI_Y0, ROI_Y0+ROI_SIZE).
  - It is within BORDER_W of any edge.
  - latched roi_en=1.
- roi_en latching:
  - Sampled only when x==0 && y==0 (frame boundary).
  - Mid-frame toggles take effect next frame; no partial outlines.
- frame_start=1 for exactly one cycle, when the delayed copy of (x==0 && y==0 && de_in) reaches the output; at reset it stays 0 until the first full frame start.
- Counter wrap: x 799->0 and y 524->0 need no special handling beyond the row_base reset.
- fb_data is ignored (not captured) whenever the matching fb_rd_en was 0.
- Reset mid-frame: all pipeline state clears. Output is blank with syncs high until the pipeline refills (L cycles); no stale pixels are emitted.

Test Plan:
- Reset then free-run a full frame with the timing model -> vga_de asserted exactly 640x480=307200 cycles per frame; first vga_de rises 4 cycles after the first de_in (RD_LAT=2).
- BRAM model returning data=address[11:0] -> at screen (0,0),(1,0),(0,1),(1,1) output 0x000; at (2,0) 0x001; at (639,479) 76799[11:0]=0xBFF; fb_addr never exceeds 76799.
- Sync alignment -> rising edge of vga_de always preceded by vga_hs high; hsync low width 96, vsync low 2 lines (1600 cycles); offset from active video identical to generator inputs.
- roi_en=1 set before a frame -> pixel (264,184)=0xF00, (265,200)=0xF00, (266,200)=fb_data, (375,295)=0xF00; roi_en pulsed at line 300 mid-frame -> no outline until next frame, then full outline.
- Blanking -> RGB=0 for every cycle with vga_de=0, even if fb_data is non-zero.
- Assert rst_n low at x=300,y=200 for 3 cycles -> outputs immediately at reset values; frame_start pulses once at the next (0,0) only.
